upsample_2x: RTL and testbench

Nearest-neighbour 2× upsampler for the decoder side of the depth-estimation network; the inverse of the 2×2 max-pool stage. It accepts a channel-interleaved pixel stream framed by sop/eop/sof/eof and emits each pixel twice horizontally and each row twice vertically. The output stream uses the same framing, so the next convolution stage needs no changes. Input is throttled with `ready_o` because the output rate is four times the input rate.

---
 rtl/upsample_2x_pkg.sv | 15 +
 rtl/RAM.sv | 35 +++
 rtl/upsample_2x.sv | 166 ++++++++++++++++
 tb/tb_upsample_2x.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_2x_pkg.sv
// upsample_2x_pkg: shared FSM state type and line-buffer RAM style selection for upsample_2x.
package upsample_2x_pkg;

    typedef enum logic [1:0] {
        S_PASS,
        S_DUP,
        S_ROW2
    } state_t;

    // Small line buffers go to fabric registers, larger ones to block RAM.
    function automatic string ram_style(input int depth);
        return (depth < 32) ? "logic" : "M10K";
    endfunction

endpackage

// File: rtl/RAM.sv
// RAM: simple dual-port line-buffer memory with one-cycle registered read.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, issued in cycle t
//   q      out  read data, valid in cycle t+1
module RAM #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 4,
    parameter string RAM_STYLE  = "logic"
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q
);

    if (RAM_STYLE == "M10K") begin : g_m10k
        (* ramstyle = "M10K" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            q <= mem[raddr];
        end
    end else begin : g_logic
        (* ramstyle = "logic" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/upsample_2x.sv
// upsample_2x: nearest-neighbour 2x upsampler for a channel-interleaved, sop/eop/sof/eof framed pixel stream.
//   clk, reset_n                    clock, asynchronous active-low reset
//   valid_i, data_i                 input sample, accepted on valid_i & ready_o
//   sop_i, eop_i, sof_i, eof_i      input framing, qualified by accept
//   ready_o                         high while the block passes input through
//   data_o, data_valid_o            output sample stream (four samples per input sample)
//   sop_o, eop_o, sof_o, eof_o      output framing pulses, coincident with data_valid_o
module upsample_2x
    import upsample_2x_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 3,
    parameter int STRING_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  sof_i,
    input  logic                  eof_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o
);

    localparam int    C  = CHANNEL_NUM;
    localparam int    L  = STRING_LEN;
    localparam int    N  = L * C;
    localparam int    AW = (N > 1) ? $clog2(N) : 1;
    localparam int    PW = (L > 1) ? $clog2(L) : 1;
    localparam int    CW = (C > 1) ? $clog2(C) : 1;
    localparam string RS = ram_style(N);

    state_t                state_q, state_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic                  rep_q, rep_d;
    logic                  eof_row_q, eof_row_d;
    logic                  v1_q, v1_d;
    logic                  ram1_q, ram1_d;
    logic [DATA_WIDTH-1:0] d1_q, d1_d;
    logic [3:0]            f1_q, f1_d;
    logic                  dv_q, dv_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            f2_q, f2_d;

    logic                  acc, sync, last_ch, last_pix, first_a, row2_last;
    logic [PW-1:0]         pe;
    logic [CW-1:0]         ce;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  unused_eop;

    // Row ends are tracked by the pix/ch counters, so eop_i carries no extra information.
    assign unused_eop = eop_i;
    assign ready_o    = state_q == S_PASS;

    RAM #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(AW),
        .RAM_STYLE (RS)
    ) u_line (
        .clk  (clk),
        .we   (acc),
        .waddr(addr),
        .wdata(data_i),
        .raddr(addr),
        .q    (ram_q)
    );

    always_comb begin
        acc       = ready_o & valid_i;
        // An accepted sop_i always restarts the row at pix 0, ch 0, dropping any partial row.
        sync      = acc & sop_i;
        pe        = sync ? '0 : pix_q;
        ce        = sync ? '0 : ch_q;
        addr      = AW'(int'(pe) * C + int'(ce));
        last_ch   = ce == CW'(C - 1);
        last_pix  = pe == PW'(L - 1);
        first_a   = acc & (pe == '0) & (ce == '0);
        row2_last = (state_q == S_ROW2) & last_pix & last_ch & rep_q;
        state_d   = state_q;
        pix_d     = pix_q;
        ch_d      = ch_q;
        rep_d     = rep_q;
        eof_row_d = eof_row_q;
        if (acc) begin
            ch_d    = last_ch ? '0 : ce + 1'b1;
            pix_d   = pe;
            state_d = last_ch ? S_DUP : S_PASS;
            if (last_ch & last_pix) eof_row_d = eof_i;
        end else if (state_q == S_DUP) begin
            ch_d = last_ch ? '0 : ch_q + 1'b1;
            if (last_ch) begin
                state_d = last_pix ? S_ROW2 : S_PASS;
                pix_d   = last_pix ? '0 : pix_q + 1'b1;
                rep_d   = 1'b0;
            end
        end else if (state_q == S_ROW2) begin
            // rep_q selects the first or second copy of the current pixel.
            ch_d = last_ch ? '0 : ch_q + 1'b1;
            if (last_ch) begin
                rep_d = ~rep_q;
                if (rep_q) begin
                    pix_d   = last_pix ? '0 : pix_q + 1'b1;
                    state_d = last_pix ? S_PASS : S_ROW2;
                end
            end
        end
        // Stage 1: the direct path is delayed one cycle to line up with the RAM read latency.
        v1_d   = acc | (state_q != S_PASS);
        ram1_d = state_q != S_PASS;
        d1_d   = data_i;
        f1_d   = {first_a | ((state_q == S_ROW2) & (pix_q == '0) & (ch_q == '0) & ~rep_q),
                  ((state_q == S_DUP) & last_pix & last_ch) | row2_last,
                  first_a & sof_i,
                  row2_last & eof_row_q};
        dv_d   = v1_q;
        data_d = v1_q ? (ram1_q ? ram_q : d1_q) : '0;
        f2_d   = f1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_PASS;
            pix_q     <= '0;
            ch_q      <= '0;
            rep_q     <= 1'b0;
            eof_row_q <= 1'b0;
            v1_q      <= 1'b0;
            ram1_q    <= 1'b0;
            d1_q      <= '0;
            f1_q      <= '0;
            dv_q      <= 1'b0;
            data_q    <= '0;
            f2_q      <= '0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            ch_q      <= ch_d;
            rep_q     <= rep_d;
            eof_row_q <= eof_row_d;
            v1_q      <= v1_d;
            ram1_q    <= ram1_d;
            d1_q      <= d1_d;
            f1_q      <= f1_d;
            dv_q      <= dv_d;
            data_q    <= data_d;
            f2_q      <= f2_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign sop_o        = f2_q[3];
    assign eop_o        = f2_q[2];
    assign sof_o        = f2_q[1];
    assign eof_o        = f2_q[0];

endmodule

// File: tb/tb_upsample_2x.sv
// tb_upsample_2x: directed self-checking bench for upsample_2x with C = 3, L = 4, DATA_WIDTH = 8.
module tb_upsample_2x;

    localparam int PER = 10;

    typedef logic [7:0] row_t [12];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
    logic       ready_o, data_valid_o, sop_o, eop_o, sof_o, eof_o;
    logic [7:0] data_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] obs_q [$];
    time         obs_t [$];

    row_t px_basic = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
    row_t px_tp    = '{8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106, 8'd107, 8'd108, 8'd109, 8'd110, 8'd111, 8'd112};
    row_t px_two   = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd30, 8'd31};
    row_t px_sgn   = '{8'h80, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h80, 8'h00, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h00};
    row_t px_rs    = '{8'd60, 8'd61, 8'd62, 8'd63, 8'd64, 8'd65, 8'd66, 8'd67, 8'd68, 8'd69, 8'd70, 8'd71};

    upsample_2x #(
        .DATA_WIDTH (8),
        .CHANNEL_NUM(3),
        .STRING_LEN (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .sop_i       (sop_i),
        .eop_i       (eop_i),
        .sof_i       (sof_i),
        .eof_i       (eof_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o)
    );

    always #(PER / 2) clk = ~clk;

    always @(negedge clk) begin
        if (data_valid_o) begin
            obs_q.push_back({data_o, sop_o, eop_o, sof_o, eof_o});
            obs_t.push_back($time);
        end
    end

    // Expected {data, sop, eop, sof, eof} for output i (0..47) of one input row.
    function automatic logic [11:0] ew(input row_t px, input int i, input bit f, input bit ef);
        int r;
        r = i % 24;
        return {px[(r / 6) * 3 + r % 3], (r == 0), (r == 23), (f && i == 0), (ef && i == 47)};
    endfunction

    function automatic logic [11:0] obs(input int i);
        return (i < obs_q.size()) ? obs_q[i] : 12'hxxx;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic e, input logic f, input logic ef);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        valid_i = 1'b1;
        data_i  = d;
        sop_i   = s;
        eop_i   = e;
        sof_i   = f;
        eof_i   = ef;
        @(negedge clk);
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
        sof_i   = 1'b0;
        eof_i   = 1'b0;
    endtask

    task automatic send_row(input row_t px, input bit f, input bit ef, input bit gap);
        for (int i = 0; i < 12; i++) begin
            put(px[i], i == 0, i == 11, f && i == 0, ef && i == 11);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (obs_q.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready_o); end
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", data_valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", data_o); end
        n_cmp++; if ({sop_o, eop_o, sof_o, eof_o} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {sop_o, eop_o, sof_o, eof_o}); end
    endtask

    task automatic test_basic();
        clear_obs();
        send_row(px_basic, 1'b1, 1'b1, 1'b0);
        wait_out(48);
        n_cmp++; if (obs_q.size() !== 48) begin n_err++; $display("FAIL basic_count got %0d want 48", obs_q.size()); end
        for (int i = 0; i < 48; i++) begin
            n_cmp++;
            if (obs(i) !== ew(px_basic, i, 1'b1, 1'b1)) begin
                n_err++;
                $display("FAIL basic[%0d] got %h want %h", i, obs(i), ew(px_basic, i, 1'b1, 1'b1));
            end
        end
    endtask

    task automatic test_throughput();
        logic [48:0] r, r_exp;
        time         t0;
        clear_obs();
        for (int i = 0; i < 49; i++) r_exp[i] = (i < 24) ? ((i % 6) < 3) : (i == 48);
        t0 = $time;
        fork
            send_row(px_tp, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 49; i++) begin
                r[i] = ready_o;
                @(negedge clk);
            end
        join
        wait_out(48);
        n_cmp++; if (r !== r_exp) begin n_err++; $display("FAIL tp_ready got %b want %b", r, r_exp); end
        n_cmp++; if (obs_q.size() !== 48) begin n_err++; $display("FAIL tp_count got %0d want 48", obs_q.size()); end
        if (obs_t.size() == 48) begin
            n_cmp++; if (obs_t[0] - t0 !== 2 * PER) begin n_err++; $display("FAIL tp_latency got %0t want %0t", obs_t[0] - t0, 2 * PER); end
            n_cmp++; if (obs_t[47] - obs_t[0] !== 47 * PER) begin n_err++; $display("FAIL tp_busy got %0t want %0t", obs_t[47] - obs_t[0], 47 * PER); end
        end
        for (int i = 0; i < 48; i++) begin
            n_cmp++;
            if (obs(i) !== ew(px_tp, i, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL tp[%0d] got %h want %h", i, obs(i), ew(px_tp, i, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_gapped();
        clear_obs();
        send_row(px_basic, 1'b1, 1'b1, 1'b1);
        wait_out(48);
        n_cmp++; if (obs_q.size() !== 48) begin n_err++; $display("FAIL gap_count got %0d want 48", obs_q.size()); end
        for (int i = 0; i < 48; i++) begin
            n_cmp++;
            if (obs(i) !== ew(px_basic, i, 1'b1, 1'b1)) begin
                n_err++;
                $display("FAIL gap[%0d] got %h want %h", i, obs(i), ew(px_basic, i, 1'b1, 1'b1));
            end
        end
    endtask

    task automatic test_signed();
        clear_obs();
        send_row(px_sgn, 1'b0, 1'b0, 1'b0);
        wait_out(48);
        n_cmp++; if (obs_q.size() !== 48) begin n_err++; $display("FAIL sgn_count got %0d want 48", obs_q.size()); end
        for (int i = 0; i < 48; i++) begin
            n_cmp++;
            if (obs(i) !== ew(px_sgn, i, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL sgn[%0d] got %h want %h", i, obs(i), ew(px_sgn, i, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_two_row();
        logic [11:0] w;
        clear_obs();
        send_row(px_basic, 1'b1, 1'b0, 1'b0);
        send_row(px_two, 1'b0, 1'b1, 1'b0);
        wait_out(96);
        n_cmp++; if (obs_q.size() !== 96) begin n_err++; $display("FAIL two_count got %0d want 96", obs_q.size()); end
        for (int i = 0; i < 96; i++) begin
            w = (i < 48) ? ew(px_basic, i, 1'b1, 1'b0) : ew(px_two, i - 48, 1'b0, 1'b1);
            n_cmp++;
            if (obs(i) !== w) begin
                n_err++;
                $display("FAIL two[%0d] got %h want %h", i, obs(i), w);
            end
        end
    endtask

    task automatic test_resync();
        clear_obs();
        for (int i = 0; i < 6; i++) put(8'(50 + i), i == 0, 1'b0, 1'b0, 1'b0);
        send_row(px_rs, 1'b1, 1'b1, 1'b0);
        wait_out(60);
        n_cmp++; if (obs_q.size() !== 60) begin n_err++; $display("FAIL rs_count got %0d want 60", obs_q.size()); end
        n_cmp++; if (obs(0) !== {8'd50, 4'b1000}) begin n_err++; $display("FAIL rs_partial got %h want %h", obs(0), {8'd50, 4'b1000}); end
        for (int i = 0; i < 48; i++) begin
            n_cmp++;
            if (obs(12 + i) !== ew(px_rs, i, 1'b1, 1'b1)) begin
                n_err++;
                $display("FAIL rs[%0d] got %h want %h", i, obs(12 + i), ew(px_rs, i, 1'b1, 1'b1));
            end
        end
    endtask

    task automatic test_reset_row2();
        int sz;
        clear_obs();
        send_row(px_basic, 1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL row2_busy got %b want 0", ready_o); end
        reset_n = 1'b0;
        #1;
        sz = obs_q.size();
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", ready_o); end
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", data_valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", data_o); end
        n_cmp++; if ({sop_o, eop_o, sof_o, eof_o} !== 4'b0000) begin n_err++; $display("FAIL rst_flags got %b want 0000", {sop_o, eop_o, sof_o, eof_o}); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (obs_q.size() !== sz) begin n_err++; $display("FAIL rst_residual got %0d want %0d", obs_q.size(), sz); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", ready_o); end
        clear_obs();
        send_row(px_basic, 1'b1, 1'b1, 1'b0);
        wait_out(48);
        n_cmp++; if (obs_q.size() !== 48) begin n_err++; $display("FAIL post_rst_count got %0d want 48", obs_q.size()); end
        for (int i = 0; i < 48; i++) begin
            n_cmp++;
            if (obs(i) !== ew(px_basic, i, 1'b1, 1'b1)) begin
                n_err++;
                $display("FAIL post_rst[%0d] got %h want %h", i, obs(i), ew(px_basic, i, 1'b1, 1'b1));
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_throughput();
        test_gapped();
        test_signed();
        test_two_row();
        test_resync();
        test_reset_row2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
